mul32_seq: RTL and testbench

MUL32_SEQ -- requirements
Module: mul32_seq

---
 rtl/mul_pkg.sv | 76 +++++++
 rtl/mul32_seq.sv | 122 ++++++++++++
 tb/tb_mul32_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package mul_pkg;

  // Operation encodings carried on the op port
  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,  // low 32 bits
    OP_MULH   = 2'd1,  // signed x signed, high 32
    OP_MULHSU = 2'd2,  // signed x unsigned, high 32
    OP_MULHU  = 2'd3   // unsigned x unsigned, high 32
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Edges from accept to out_valid rising
  localparam int MUL_LAT = 6;
  // Number of 16x16 partial products per request
  localparam int NUM_PARTS = 4;

  // Latched request: operand magnitudes plus the sign of the product
  typedef struct packed {
    op_e         op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg;
  } req_t;

  // Build the latched request. |0x80000000| = 0x80000000 still fits in
  // 32 unsigned bits, so no extra magnitude bit is needed.
  function automatic req_t make_req(input op_e o, input logic [31:0] a,
                                    input logic [31:0] b);
    req_t r;
    logic sa, sb;
    sa      = (o == OP_MULH) || (o == OP_MULHSU);
    sb      = (o == OP_MULH);
    r.op    = o;
    r.a_mag = (sa && a[31]) ? (~a + 32'd1) : a;
    r.b_mag = (sb && b[31]) ? (~b + 32'd1) : b;
    r.neg   = (sa && a[31]) ^ (sb && b[31]);
    return r;
  endfunction

  // 16-bit operand halves for partial product idx: LL, LH, HL, HH
  function automatic logic [31:0] part_ops(input req_t r, input logic [1:0] idx);
    logic [15:0] ah, bh;
    ah = idx[1] ? r.a_mag[31:16] : r.a_mag[15:0];
    bh = idx[0] ? r.b_mag[31:16] : r.b_mag[15:0];
    return {ah, bh};
  endfunction

  // Left shift applied when partial product idx is accumulated
  function automatic logic [63:0] part_shift(input logic [31:0] p,
                                             input logic [1:0] idx);
    logic [63:0] w;
    w = {32'd0, p};
    case (idx)
      2'd0:    return w;
      2'd3:    return w << 32;
      default: return w << 16;
    endcase
  endfunction

  // Apply sign and pick the requested half of the 64-bit product
  function automatic logic [31:0] select_result(input op_e o, input logic neg,
                                                input logic [63:0] acc);
    logic [63:0] full;
    full = neg ? (~acc + 64'd1) : acc;
    return (o == OP_MUL) ? full[31:0] : full[63:32];
  endfunction

endpackage

// File: rtl/mul32_seq.sv
// Sequential 32x32 multiplier built from four 16x16 passes through an
// external registered 18x18 signed multiplier. Magnitudes are multiplied
// unsigned and the sign is fixed up once at the end.
module mul32_seq
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        mult_en,
  output logic [17:0] mult_a,
  output logic [17:0] mult_b,
  input  logic [35:0] mult_p
);

  state_e      state;
  logic [1:0]  cnt;
  req_t        req;
  req_t        new_req;
  logic [63:0] acc;
  logic        pend_vld;
  logic [1:0]  pend_sel;
  logic        accept;
  logic [31:0] first_ops;
  logic [31:0] next_ops;

  // Upper product bits are always zero for zero-extended 16-bit operands
  logic unused_p_hi;
  assign unused_p_hi = ^mult_p[35:32];

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign new_req   = make_req(op_e'(op), a, b);
  assign first_ops = part_ops(new_req, 2'd0);
  assign next_ops  = part_ops(req, cnt + 2'd1);

  // Control FSM: issues the four partial products, then sign-fixes and
  // holds the result until the consumer takes it. kill beats everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      req       <= '0;
      mult_en   <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (kill && state != S_IDLE) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      mult_en   <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req     <= new_req;
            cnt     <= 2'd0;
            mult_en <= 1'b1;
            mult_a  <= {2'b00, first_ops[31:16]};
            mult_b  <= {2'b00, first_ops[15:0]};
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt == 2'(NUM_PARTS - 1)) begin
            mult_en <= 1'b0;
            mult_a  <= '0;
            mult_b  <= '0;
            state   <= S_DRAIN;
          end else begin
            cnt    <= cnt + 2'd1;
            mult_a <= {2'b00, next_ops[31:16]};
            mult_b <= {2'b00, next_ops[15:0]};
          end
        end
        S_DRAIN: state <= S_FIX;
        S_FIX: begin
          result    <= select_result(req.op, req.neg, acc);
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Accumulator: each product lands one cycle after its issue cycle, so the
  // issue index is delayed one stage and used to pick the shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      pend_vld <= 1'b0;
      pend_sel <= 2'd0;
    end else begin
      pend_vld <= mult_en;
      pend_sel <= cnt;
      if (accept)
        acc <= '0;
      else if (pend_vld)
        acc <= acc + part_shift(mult_p[31:0], pend_sel);
    end
  end

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq with a behavioural 18x18 multiplier.
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, kill, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  logic        mult_en;
  logic [17:0] mult_a, mult_b;
  logic [35:0] mult_p;
  logic signed [35:0] prod;

  int n_vec = 0;
  int n_bad = 0;

  mul32_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .mult_en(mult_en),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p)
  );

  always #5 clk = ~clk;

  // External registered signed multiplier
  assign prod = $signed(mult_a) * $signed(mult_b);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mult_p <= '0;
    else if (mult_en) mult_p <= prod;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Reference: full-width arithmetic on the operands as the op defines them
  function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint sx, sy, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    case (o)
      2'd0: p = {32'd0, x} * {32'd0, y};
      2'd1: p = 64'(sx * sy);
      2'd2: p = 64'(sx * uy);
      default: p = {32'd0, x} * {32'd0, y};
    endcase
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE and pass the accept edge
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    check("ready_before_accept", in_ready, 1);
    tick;
    in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid and mult_en cycles on the way
  task automatic wait_out(output logic [31:0] r, output int lat, output int ens);
    lat = 0; ens = 0;
    while (!out_valid && lat < 20) begin
      if (mult_en) ens++;
      tick;
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    r = result;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("ready_after_hs", in_ready, 1);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
    logic [31:0] r;
    int lat, ens;
    issue(o, x, y);
    wait_out(r, lat, ens);
    check(name, r, exp);
    check("latency", lat, 6);
    check("mult_en_cycles", ens, 4);
    consume;
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] r, r0, x, y;
    logic [1:0]  o;
    int lat, ens;
    logic seen;

    rst = 1'b1; in_valid = 0; kill = 0; out_ready = 0; op = 0; a = 0; b = 0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_mult_en", mult_en, 0);
    check("rst_mult_ab", {mult_a, mult_b}, 0);
    #14 rst = 1'b0;
    tick;
    check("rst_in_ready", in_ready, 1);

    vecs.push_back('{2'd0, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF1});
    vecs.push_back('{2'd1, 32'h80000000, 32'h80000000, 32'h40000000});
    vecs.push_back('{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{2'd0, 32'd7,        32'd6,        32'd42});
    vecs.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{2'd1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF});
    vecs.push_back('{2'd3, 32'h80000000, 32'h00000002, 32'h00000001});
    vecs.push_back('{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{2'd0, 32'h00010000, 32'h00010000, 32'h00000000});
    vecs.push_back('{2'd1, 32'h00000000, 32'h87654321, 32'h00000000});

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      check("idle_mult_ab", {mult_a, mult_b}, 0);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i % 8 == 0) x = 32'h80000000;
      if (i % 8 == 1) y = 32'h80000000;
      run_op($sformatf("rand%0d", i), o, x, y, ref_mul(o, x, y));
    end

    // Output backpressure: result stays put, second request ignored
    issue(2'd3, 32'h12345678, 32'h9ABCDEF0);
    wait_out(r0, lat, ens);
    check("hold_value", r0, ref_mul(2'd3, 32'h12345678, 32'h9ABCDEF0));
    op = 2'd0; a = 32'd5; b = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("hold_result", result, r0);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    consume;

    // kill during the second issue cycle
    issue(2'd0, 32'd100, 32'd200);
    tick;
    kill = 1'b1;
    tick;
    kill = 1'b0;
    check("kill_in_ready", in_ready, 1);
    check("kill_mult_en", mult_en, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    check("kill_no_valid", seen, 0);
    run_op("after_kill", 2'd0, 32'd7, 32'd6, 32'd42);

    // kill together with the output handshake: not delivered, back to idle
    issue(2'd0, 32'd9, 32'd9);
    wait_out(r, lat, ens);
    check("kill_hs_value", r, 32'd81);
    kill = 1'b1; out_ready = 1'b1;
    tick;
    kill = 1'b0; out_ready = 1'b0;
    check("kill_hs_valid", out_valid, 0);
    check("kill_hs_ready", in_ready, 1);

    // kill in IDLE does not block acceptance
    op = 2'd0; a = 32'd11; b = 32'd13; in_valid = 1'b1; kill = 1'b1;
    tick;
    in_valid = 1'b0; kill = 1'b0;
    check("idle_kill_accepted", in_ready, 0);
    wait_out(r, lat, ens);
    check("idle_kill_result", r, 32'd143);
    check("idle_kill_latency", lat, 6);
    consume;

    // Asynchronous reset while draining
    issue(2'd3, 32'hDEADBEEF, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) tick;
    check("drain_mult_en", mult_en, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_mult_en", mult_en, 0);
    check("arst_mult_ab", {mult_a, mult_b}, 0);
    #3 rst = 1'b0;
    tick;
    check("arst_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    check("arst_no_valid", seen, 0);
    run_op("after_rst", 2'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
